dcache_store_buffer: RTL and testbench
======================================

// Module: dcache_store_buffer
// PURPOSE
//   Post-commit store buffer ahead of the data cache. Queues committed word stores, merges a new store into the
//   youngest same-word entry, and drains one entry at a time to the cache's ufp port. The ufp request registers
//   it drives feed the cache's byte-lane placement into the 256-bit line and 32-bit line write mask.
//   Also flags loads that hit a pending store word, so the load path stalls until the buffer drains.
// PARAMETERS
//   DEPTH   4   entry count; power of 2, >=2
// PORTS
//   clk             in   1    clock
//   rst             in   1    synchronous active-high reset
//   st_valid        in   1    committed store offered
//   st_ready        out  1    buffer can accept; = (count < DEPTH), from registers only
//   st_addr         in   32   store byte address; [1:0] must be 2'b00
//   st_wdata        in   32   store data, byte lanes already aligned
//   st_wmask        in   4    byte enables
//   drain_en        in   1    cache-port arbiter grant to this buffer
//   ufp_addr        out  32   cache request address, [1:0]=0, registered
//   ufp_wdata       out  32   cache write data, registered
//   ufp_wmask       out  4    cache write mask, registered; nonzero = request active
//   ufp_rmask       out  4    tied 4'b0
//   ufp_resp        in   1    cache done pulse for the active request
//   ld_check_valid  in   1    load address probe valid
//   ld_check_addr   in   32   load byte address
//   ld_conflict     out  1    probe word matches any valid entry (combinational)
//   sb_empty        out  1    count == 0 and no request active
// BEHAVIOUR
//   Reset: all entries invalid, count=0, head=tail=0, FSM=IDLE, ufp_addr/ufp_wdata/ufp_wmask=0.
//   Reset mid-request drops the request; the cache port sees ufp_wmask=0 next cycle.
//   Enqueue (st_valid&&st_ready):
//     - st_wmask==0: accept and discard; no state change.
//     - Otherwise merge if tail-1 is valid, has word addr == st_addr[31:2], and is mergeable:
//       data bytes with st_wmask set overwrite; mask |= st_wmask; count unchanged.
//     - Otherwise write a new entry at tail; tail++ (wraps at DEPTH); count++.
//   Mergeable: the entry is not in flight (state==REQ and entry==head), and not being loaded into ufp regs
//   this same edge.
//   FSM IDLE: if count>0 && drain_en, load ufp regs from head at the edge; go to REQ.
//   FSM REQ: hold ufp_* stable and ignore drain_en until ufp_resp. On ufp_resp, pop head (head++, count--).
//     If count-after-pop > 0 && drain_en, load the next head and stay in REQ (back-to-back, no bubble).
//     Otherwise ufp_wmask=0 and go to IDLE.
//   Simultaneous enqueue + pop: count unchanged. Enqueue while full is impossible because st_ready=0.
//   st_ready does not look ahead on ufp_resp.
//   Store-to-cache latency: 1 cycle from enqueue into an empty, granted buffer to ufp_wmask!=0.
//   ld_conflict = ld_check_valid && any valid entry (including in-flight) has word addr == ld_check_addr[31:2].
//     A same-cycle incoming store is not checked.
//   Ordering: drain is strictly FIFO; merging never reorders, because it targets only the youngest entry.
// STRUCTURE
//   Shared package (dcache_pkg): sb_entry_t {logic valid; logic [29:0] waddr; logic [31:0] data; logic [3:0] mask},
//   sb_state_t enum {SB_IDLE, SB_REQ}, and localparam SB_PTR_W = $clog2(DEPTH).
//   Sub-module: sb_byte_merge (combinational 4-lane data/mask merge), used for the tail merge.
//   Everything else is inline: entry array, head/tail/count registers, FSM, conflict compare.
// TESTING
//   1. Store 0x100 / 0xDEADBEEF / mask 4'hF, drain_en=1 -> next cycle ufp_addr=0x100, ufp_wmask=F;
//      ufp_resp 3 cycles later -> sb_empty=1.
//   2. Stores 0x200 m=4'h1 d=0x11, then 0x200 m=4'h4 d=0x00220000, drain_en=0 -> one entry, mask=5, data=0x..22..11.
//      Then grant -> single ufp write.
//   3. Fill 4 distinct words with drain_en=0 -> st_ready=0. A 5th st_valid is not accepted.
//      ufp_resp then pops one -> st_ready=1 on the following cycle.
//   4. Entry 0x300 in flight; new store to 0x300 -> new entry, no merge; two ufp writes in order.
//      Back-to-back with no IDLE cycle.
//   5. Pending 0x404; probe ld_check_addr=0x406 -> ld_conflict=1; probe 0x408 -> 0.
//      After the drain, probe 0x406 -> 0.
//   6. rst asserted while in REQ with 3 entries -> next cycle ufp_wmask=0, sb_empty=1, st_ready=1.
//      Wrap-around: 9 enqueue/drain pairs keep FIFO data order.

Source files
------------

// File: rtl/dcache_store_buffer_pkg.sv
// Shared types for the data-cache store buffer: entry record, drain FSM states
// and the default depth.
package dcache_store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic        valid;
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_REQ
  } sb_state_t;

endpackage

// File: rtl/dcache_store_buffer_if.sv
// Store-side, cache-port and load-probe signals of the store buffer.
// master = core/cache environment, slave = the store buffer itself.
interface dcache_store_buffer_if;

  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        drain_en;
  logic [31:0] ufp_addr;
  logic [31:0] ufp_wdata;
  logic [3:0]  ufp_wmask;
  logic [3:0]  ufp_rmask;
  logic        ufp_resp;
  logic        ld_check_valid;
  logic [31:0] ld_check_addr;
  logic        ld_conflict;
  logic        sb_empty;

  modport master (
    output st_valid, st_addr, st_wdata, st_wmask, drain_en, ufp_resp,
           ld_check_valid, ld_check_addr,
    input  st_ready, ufp_addr, ufp_wdata, ufp_wmask, ufp_rmask, ld_conflict, sb_empty
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_wmask, drain_en, ufp_resp,
           ld_check_valid, ld_check_addr,
    output st_ready, ufp_addr, ufp_wdata, ufp_wmask, ufp_rmask, ld_conflict, sb_empty
  );

endinterface

// File: rtl/dcache_store_buffer_byte_merge.sv
// Combinational 4-lane byte merge: lanes enabled in new_mask take the new data,
// the rest keep the old data; masks are OR-ed.
module sb_byte_merge (
  input  logic [31:0] old_data,
  input  logic [3:0]  old_mask,
  input  logic [31:0] new_data,
  input  logic [3:0]  new_mask,
  output logic [31:0] merged_data,
  output logic [3:0]  merged_mask
);

  always_comb begin
    merged_data = old_data;
    merged_mask = old_mask | new_mask;
    for (int i = 0; i < 4; i++) begin
      if (new_mask[i]) merged_data[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/dcache_store_buffer.sv
// Post-commit store buffer: FIFO of word stores with youngest-entry merging,
// one-at-a-time drain to the cache ufp port, and a load-conflict probe.
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input logic                  clk,
  input logic                  rst,
  dcache_store_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  sb_entry_t        entries [DEPTH];
  ptr_t             head;
  ptr_t             tail;
  logic [CNT_W-1:0] count;
  sb_state_t        state;
  sb_state_t        state_next;

  logic [31:0] ufp_addr_q;
  logic [31:0] ufp_wdata_q;
  logic [3:0]  ufp_wmask_q;

  logic        st_ready_int;
  logic        accept;
  logic        pop;
  logic        load;
  ptr_t        load_idx;
  ptr_t        youngest;
  logic        merge;
  logic        push_new;
  logic        probe_hit;
  logic [31:0] merged_data;
  logic [3:0]  merged_mask;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{bus.st_addr[1:0], bus.ld_check_addr[1:0]};

  sb_byte_merge u_merge (
    .old_data    (entries[youngest].data),
    .old_mask    (entries[youngest].mask),
    .new_data    (bus.st_wdata),
    .new_mask    (bus.st_wmask),
    .merged_data (merged_data),
    .merged_mask (merged_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= SB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load)     state_next = SB_REQ;
    else if (pop) state_next = SB_IDLE;
  end

  // A merge may only touch the youngest entry, and never one that the cache
  // already owns or is about to own at this edge.
  always_comb begin
    st_ready_int = (count < CNT_W'(DEPTH));
    accept       = bus.st_valid && st_ready_int && (bus.st_wmask != 4'b0000);
    pop          = (state == SB_REQ) && bus.ufp_resp;
    youngest     = tail - ptr_t'(1);
    load         = 1'b0;
    load_idx     = head;
    if (bus.drain_en) begin
      if (state == SB_IDLE && count != '0) begin
        load = 1'b1;
      end else if (pop && count > CNT_W'(1)) begin
        load     = 1'b1;
        load_idx = head + ptr_t'(1);
      end
    end
    merge = accept && entries[youngest].valid
         && (entries[youngest].waddr == bus.st_addr[31:2])
         && !(state == SB_REQ && youngest == head)
         && !(load && load_idx == youngest);
    push_new = accept && !merge;
    probe_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && entries[i].waddr == bus.ld_check_addr[31:2]) probe_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ufp_addr_q  <= '0;
      ufp_wdata_q <= '0;
      ufp_wmask_q <= '0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + ptr_t'(1);
      end
      if (merge) begin
        entries[youngest].data <= merged_data;
        entries[youngest].mask <= merged_mask;
      end
      if (push_new) begin
        entries[tail].valid <= 1'b1;
        entries[tail].waddr <= bus.st_addr[31:2];
        entries[tail].data  <= bus.st_wdata;
        entries[tail].mask  <= bus.st_wmask;
        tail                <= tail + ptr_t'(1);
      end
      count <= count + CNT_W'(push_new) - CNT_W'(pop);
      if (load) begin
        ufp_addr_q  <= {entries[load_idx].waddr, 2'b00};
        ufp_wdata_q <= entries[load_idx].data;
        ufp_wmask_q <= entries[load_idx].mask;
      end else if (pop) begin
        ufp_wmask_q <= 4'b0000;
      end
    end
  end

  assign bus.st_ready    = st_ready_int;
  assign bus.ufp_addr    = ufp_addr_q;
  assign bus.ufp_wdata   = ufp_wdata_q;
  assign bus.ufp_wmask   = ufp_wmask_q;
  assign bus.ufp_rmask   = 4'b0000;
  assign bus.ld_conflict = bus.ld_check_valid && probe_hit;
  assign bus.sb_empty    = (count == '0) && (ufp_wmask_q == 4'b0000);

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Self-checking bench for dcache_store_buffer: directed vector table, corner
// sequences, and random traffic against a queue-based reference model.
module tb_dcache_store_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dcache_store_buffer_if bus();

  dcache_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic        drain_en;
    logic        ufp_resp;
    logic        ld_valid;
    logic [31:0] ld_addr;
  } stim_t;

  typedef struct {
    logic        st_ready;
    logic [3:0]  ufp_wmask;
    logic [31:0] ufp_addr;
    logic [31:0] ufp_wdata;
    logic        ld_conflict;
    logic        sb_empty;
  } expect_t;

  typedef struct {
    stim_t   s;
    expect_t e;
  } vec_t;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } m_ent_t;

  int checks = 0;
  int passes = 0;

  // Reference model: the pending stores as a FIFO of words, front entry owned
  // by the cache whenever m_active is set.
  m_ent_t      mq[$];
  bit          m_active = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_mask = '0;

  function automatic stim_t mk(logic v, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                               logic dr, logic rs, logic lv, logic [31:0] la);
    stim_t s;
    s.rst = 1'b0; s.st_valid = v; s.st_addr = a; s.st_wdata = d; s.st_wmask = m;
    s.drain_en = dr; s.ufp_resp = rs; s.ld_valid = lv; s.ld_addr = la;
    return s;
  endfunction

  function automatic expect_t ex(logic rdy, logic [3:0] wm, logic [31:0] a, logic [31:0] d,
                                 logic conf, logic empty);
    expect_t e;
    e.st_ready = rdy; e.ufp_wmask = wm; e.ufp_addr = a; e.ufp_wdata = d;
    e.ld_conflict = conf; e.sb_empty = empty;
    return e;
  endfunction

  function automatic expect_t modelPredict(stim_t s);
    expect_t e;
    e.st_ready    = (mq.size() < DEPTH);
    e.ufp_wmask   = m_mask;
    e.ufp_addr    = m_addr;
    e.ufp_wdata   = m_data;
    e.ld_conflict = 1'b0;
    foreach (mq[i]) if (s.ld_valid && mq[i].waddr == s.ld_addr[31:2]) e.ld_conflict = 1'b1;
    e.sb_empty    = (mq.size() == 0) && !m_active;
    return e;
  endfunction

  task automatic modelStep(input stim_t s);
    int     sz;
    bit     pop, ld, acc, mrg;
    m_ent_t t;
    if (s.rst) begin
      mq.delete();
      m_active = 1'b0; m_addr = '0; m_data = '0; m_mask = '0;
      return;
    end
    sz  = mq.size();
    pop = m_active && s.ufp_resp;
    ld  = s.drain_en && ((!m_active && sz > 0) || (pop && sz > 1));
    acc = s.st_valid && (sz < DEPTH) && (s.st_wmask != 4'b0000);
    mrg = 1'b0;
    if (acc && sz > 0 && mq[sz-1].waddr == s.st_addr[31:2]) begin
      mrg = 1'b1;
      if (m_active && sz == 1)         mrg = 1'b0;
      if (ld && !m_active && sz == 1)  mrg = 1'b0;
      if (ld && pop && sz == 2)        mrg = 1'b0;
    end
    if (pop) void'(mq.pop_front());
    if (ld) begin
      m_addr = {mq[0].waddr, 2'b00}; m_data = mq[0].data; m_mask = mq[0].mask;
      m_active = 1'b1;
    end else if (pop) begin
      m_mask = 4'b0000; m_active = 1'b0;
    end
    if (acc) begin
      if (mrg) begin
        t = mq[mq.size()-1];
        for (int b = 0; b < 4; b++) if (s.st_wmask[b]) t.data[8*b +: 8] = s.st_wdata[8*b +: 8];
        t.mask = t.mask | s.st_wmask;
        mq[mq.size()-1] = t;
      end else begin
        t.waddr = s.st_addr[31:2]; t.data = s.st_wdata; t.mask = s.st_wmask;
        mq.push_back(t);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    rst                = s.rst;
    bus.st_valid       = s.st_valid;
    bus.st_addr        = s.st_addr;
    bus.st_wdata       = s.st_wdata;
    bus.st_wmask       = s.st_wmask;
    bus.drain_en       = s.drain_en;
    bus.ufp_resp       = s.ufp_resp;
    bus.ld_check_valid = s.ld_valid;
    bus.ld_check_addr  = s.ld_addr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input expect_t e);
    chk({tag, ".st_ready"},    32'(bus.st_ready),    32'(e.st_ready));
    chk({tag, ".ufp_wmask"},   32'(bus.ufp_wmask),   32'(e.ufp_wmask));
    chk({tag, ".ufp_rmask"},   32'(bus.ufp_rmask),   32'h0);
    chk({tag, ".ld_conflict"}, 32'(bus.ld_conflict), 32'(e.ld_conflict));
    chk({tag, ".sb_empty"},    32'(bus.sb_empty),    32'(e.sb_empty));
    if (e.ufp_wmask != 4'b0000) begin
      chk({tag, ".ufp_addr"},  bus.ufp_addr,  e.ufp_addr);
      chk({tag, ".ufp_wdata"}, bus.ufp_wdata, e.ufp_wdata);
    end
  endtask

  task automatic runCycle(input string tag, input stim_t s);
    applyStimulus(s);
    if (!s.rst) checkOutput(tag, modelPredict(s));
    modelStep(s);
  endtask

  task automatic doReset();
    stim_t s;
    s = mk(0, 0, 0, 0, 0, 0, 0, 0);
    s.rst = 1'b1;
    runCycle("reset", s);
    runCycle("reset", s);
  endtask

  task automatic drainAll(input string tag);
    for (int n = 0; n < 60 && (mq.size() != 0 || m_active); n++)
      runCycle(tag, mk(0, 0, 0, 0, 1, m_active, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk({tag, ".sb_empty"}, 32'(bus.sb_empty), 32'h1);
    modelStep(mk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  vec_t vecs[$];

  initial begin
    stim_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);

    // Single store drains after grant; merged stores give one write; load probes.
    vecs.push_back('{mk(1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 0, 0, 0), ex(1, 4'h0, 0, 0, 0, 1)});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 0, 0, 0), ex(1, 4'h0, 0, 0, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 0, 0, 0), ex(1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 0, 0, 0), ex(1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 1, 0, 0), ex(1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 0, 0, 0), ex(1, 4'h0, 0, 0, 0, 1)});
    vecs.push_back('{mk(1, 32'h200, 32'h11, 4'h1, 0, 0, 0, 0), ex(1, 4'h0, 0, 0, 0, 1)});
    vecs.push_back('{mk(1, 32'h200, 32'h00220000, 4'h4, 0, 0, 0, 0), ex(1, 4'h0, 0, 0, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 32'h203), ex(1, 4'h0, 0, 0, 1, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 0, 0, 0), ex(1, 4'h0, 0, 0, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0), ex(1, 4'h5, 32'h200, 32'h00220011, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 1, 0, 0), ex(1, 4'h5, 32'h200, 32'h00220011, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0), ex(1, 4'h0, 0, 0, 0, 1)});
    vecs.push_back('{mk(1, 32'h404, 32'h12345678, 4'hF, 0, 0, 0, 0), ex(1, 4'h0, 0, 0, 0, 1)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 32'h406), ex(1, 4'h0, 0, 0, 1, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 32'h408), ex(1, 4'h0, 0, 0, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 32'h406), ex(1, 4'h0, 0, 0, 0, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 0, 1, 32'h406), ex(1, 4'h0, 0, 0, 1, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 1, 1, 32'h406), ex(1, 4'hF, 32'h404, 32'h12345678, 1, 0)});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 32'h406), ex(1, 4'h0, 0, 0, 0, 1)});
    vecs.push_back('{mk(1, 32'h500, 32'hFFFF, 4'h0, 1, 0, 1, 32'h500), ex(1, 4'h0, 0, 0, 0, 1)});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 0, 1, 32'h500), ex(1, 4'h0, 0, 0, 0, 1)});

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("tbl[%0d]", i), vecs[i].e);
      modelStep(vecs[i].s);
    end

    // Full buffer: st_ready drops, a fifth store is refused, no look-ahead on ufp_resp.
    for (int i = 0; i < 4; i++)
      runCycle("fill", mk(1, 32'h1000 + 32'(16 * i), 32'hA0 + 32'(i), 4'hF, 0, 0, 0, 0));
    runCycle("full", idle);
    chk("full.st_ready", 32'(bus.st_ready), 32'h0);
    runCycle("full.extra", mk(1, 32'h2000, 32'hBAD, 4'hF, 0, 0, 1, 32'h2000));
    chk("full.extra_conflict", 32'(bus.ld_conflict), 32'h0);
    runCycle("full.grant", mk(0, 0, 0, 0, 1, 0, 0, 0));
    runCycle("full.resp", mk(0, 0, 0, 0, 0, 1, 0, 0));
    chk("full.resp_st_ready", 32'(bus.st_ready), 32'h0);
    runCycle("full.after", idle);
    chk("full.after_st_ready", 32'(bus.st_ready), 32'h1);
    drainAll("full.drain");

    // In-flight entry is not merged into; the two writes go out back-to-back.
    runCycle("inflight", mk(1, 32'h300, 32'h1, 4'hF, 1, 0, 0, 0));
    runCycle("inflight", mk(0, 0, 0, 0, 1, 0, 0, 0));
    runCycle("inflight", mk(1, 32'h300, 32'h2, 4'hF, 1, 0, 0, 0));
    chk("inflight.first_data", bus.ufp_wdata, 32'h1);
    runCycle("inflight", mk(0, 0, 0, 0, 1, 1, 0, 0));
    runCycle("inflight", mk(0, 0, 0, 0, 1, 1, 0, 0));
    chk("inflight.b2b_wmask", 32'(bus.ufp_wmask), 32'hF);
    chk("inflight.second_data", bus.ufp_wdata, 32'h2);
    runCycle("inflight", idle);
    chk("inflight.sb_empty", 32'(bus.sb_empty), 32'h1);

    // Reset while a request is active with three entries queued.
    for (int i = 0; i < 3; i++)
      runCycle("rstreq", mk(1, 32'h600 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF, 0, 0, 0, 0));
    runCycle("rstreq", mk(0, 0, 0, 0, 1, 0, 0, 0));
    runCycle("rstreq", idle);
    chk("rstreq.active", 32'(bus.ufp_wmask), 32'hF);
    begin
      stim_t r;
      r = idle;
      r.rst = 1'b1;
      runCycle("rstreq", r);
    end
    runCycle("rstreq.after", idle);
    chk("rstreq.ufp_wmask", 32'(bus.ufp_wmask), 32'h0);
    chk("rstreq.sb_empty", 32'(bus.sb_empty), 32'h1);
    chk("rstreq.st_ready", 32'(bus.st_ready), 32'h1);

    // Wrap-around: nine store/drain pairs carry their data out in order.
    for (int k = 0; k < 9; k++) begin
      runCycle("wrap", mk(1, 32'h700 + 32'(4 * k), 32'hC000 + 32'(k), 4'hF, 1, 0, 0, 0));
      runCycle("wrap", mk(0, 0, 0, 0, 1, 0, 0, 0));
      runCycle("wrap", mk(0, 0, 0, 0, 1, 1, 0, 0));
      chk($sformatf("wrap[%0d].data", k), bus.ufp_wdata, 32'hC000 + 32'(k));
      chk($sformatf("wrap[%0d].addr", k), bus.ufp_addr, 32'h700 + 32'(4 * k));
    end

    // Random traffic on a few hot words so merges, conflicts and fills all occur.
    for (int c = 0; c < 3000; c++) begin
      stim_t s;
      s = mk($urandom % 2, 32'h1000 + 32'(4 * $urandom_range(0, 3)), $urandom, 4'($urandom % 16),
             ($urandom % 4) != 0, m_active && ($urandom % 3 == 0),
             $urandom % 2, 32'h1000 + 32'($urandom_range(0, 19)));
      s.rst = ($urandom % 500 == 0);
      runCycle("rand", s);
    end
    drainAll("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
